pim_buffer_banked: RTL and testbench

Parametrised, multi-bank successor to the single-macro PIM buffer. It keeps the CPU-side load/store port, with byte-strobed writes and 1-cycle reads. It adds a word-interleaved bank array and a second, independent streaming read port that feeds the PIM engine with length-N bursts under valid/ready backpressure. It sits between the core's data-memory interconnect and the PIM compute engine.

---
 rtl/pim_buf_pkg.sv | 20 ++
 rtl/pim_buf_bank.sv | 33 +++
 rtl/pim_buffer_banked.sv | 196 +++++++++++++++++++
 tb/tb_pim_buffer_banked.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pim_buf_pkg.sv
// Shared types and width helpers for the banked PIM buffer.
// Defaults give two banks of 3584 words (28 KB total).
package pim_buf_pkg;

  localparam int DEF_NUM_BANKS      = 2;
  localparam int DEF_BANK_DEPTH     = 3584;
  localparam int DEF_MAX_BURST_LOG2 = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } str_state_e;

  // Index width that stays >= 1 so single-bank builds keep legal vectors
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pim_buf_bank.sv
// Behavioural 1RW SRAM bank: byte write enables, registered read.
// Same ports as the foundry macro, so either can be used.
module pim_buf_bank #(
  parameter int DEPTH = 3584,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pim_buffer_banked.sv
// Banked PIM buffer: CPU load/store port plus a burst stream port
// with a 2-entry output FIFO; the CPU always wins bank conflicts.
module pim_buffer_banked
  import pim_buf_pkg::*;
#(
  parameter int NUM_BANKS      = DEF_NUM_BANKS,
  parameter int BANK_DEPTH     = DEF_BANK_DEPTH,
  parameter int MAX_BURST_LOG2 = DEF_MAX_BURST_LOG2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [31:0]             i_buf_addr,
  input  logic [31:0]             i_buf_wr_data,
  input  logic [3:0]              i_buf_size,
  input  logic                    i_buf_write,
  input  logic                    i_buf_read,
  output logic [31:0]             o_buf_rd_data,
  output logic                    o_buf_rd_valid,
  input  logic                    i_str_start,
  input  logic [31:0]             i_str_addr,
  input  logic [MAX_BURST_LOG2:0] i_str_len,
  output logic                    o_str_busy,
  output logic [31:0]             o_str_data,
  output logic                    o_str_valid,
  input  logic                    i_str_ready,
  output logic                    o_str_done
);

  localparam int TOTAL     = NUM_BANKS * BANK_DEPTH;
  localparam int BANK_BITS = idx_bits(NUM_BANKS);
  localparam int ROW_BITS  = idx_bits(BANK_DEPTH);
  localparam int LW        = MAX_BURST_LOG2 + 1;

  logic [29:0]          cpu_lin;
  logic [BANK_BITS-1:0] cpu_bank;
  logic [ROW_BITS-1:0]  cpu_row;
  logic                 cpu_req;
  logic                 unused_addr;

  str_state_e           state_q;
  logic                 busy_q, done_q;
  logic [29:0]          str_word_q, str_next;
  logic [LW-1:0]        iss_rem_q, beat_rem_q;
  logic [BANK_BITS-1:0] str_bank;
  logic [ROW_BITS-1:0]  str_row;
  logic                 issue;

  logic                 issued_q;
  logic [BANK_BITS-1:0] iss_bank_q;
  logic [31:0]          fifo_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [31:0]          live, head;
  logic                 str_valid, pop, push, pop_st;

  logic                 rd_pend_q, rd_pend_d;
  logic [BANK_BITS-1:0] rd_bank_q;
  logic [31:0]          rd_hold_q;
  logic [31:0]          bank_rdata [NUM_BANKS];

  assign unused_addr = ^{i_buf_addr[1:0], i_str_addr[1:0]};

  assign cpu_lin  = 30'(i_buf_addr[31:2] % 30'(TOTAL));
  assign cpu_bank = BANK_BITS'(cpu_lin % 30'(NUM_BANKS));
  assign cpu_row  = ROW_BITS'(cpu_lin / 30'(NUM_BANKS));
  assign cpu_req  = i_buf_write | i_buf_read;

  assign str_bank = BANK_BITS'(str_word_q % 30'(NUM_BANKS));
  assign str_row  = ROW_BITS'(str_word_q / 30'(NUM_BANKS));
  assign str_next = (str_word_q == 30'(TOTAL - 1)) ? '0
                  : str_word_q + 30'd1;

  // In-flight read plus stored words never exceed the two FIFO slots
  assign issue = (state_q == ST_RUN) && (iss_rem_q != '0)
              && ((cnt_q + {1'b0, issued_q}) < 2'd2)
              && !(cpu_req && (cpu_bank == str_bank));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                cpu_sel, str_sel;
    logic [ROW_BITS-1:0] addr;
    assign cpu_sel = cpu_req && (cpu_bank == BANK_BITS'(b));
    assign str_sel = issue && (str_bank == BANK_BITS'(b));
    assign addr    = cpu_sel ? cpu_row : str_row;
    pim_buf_bank #(
      .DEPTH (BANK_DEPTH),
      .AW    (ROW_BITS)
    ) u_bank (
      .clk_i   (i_clk),
      .en_i    (cpu_sel | str_sel),
      .we_i    (cpu_sel & i_buf_write),
      .be_i    (i_buf_size),
      .addr_i  (addr),
      .wdata_i (i_buf_wr_data),
      .rdata_o (bank_rdata[b])
    );
  end

  // CPU read: a simultaneous write suppresses the read
  assign rd_pend_d      = i_buf_read & ~i_buf_write;
  assign o_buf_rd_valid = rd_pend_q;
  assign o_buf_rd_data  = rd_pend_q ? bank_rdata[rd_bank_q] : rd_hold_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_pend_q <= 1'b0;
      rd_bank_q <= '0;
      rd_hold_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      if (rd_pend_d) rd_bank_q <= cpu_bank;
      if (rd_pend_q) rd_hold_q <= bank_rdata[rd_bank_q];
    end
  end

  // The word still sitting in the bank output register acts as FIFO head
  assign live      = bank_rdata[iss_bank_q];
  assign str_valid = (cnt_q != 2'd0) | issued_q;
  assign head      = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : live;
  assign pop       = str_valid & i_str_ready;
  assign pop_st    = pop & (cnt_q != 2'd0);
  assign push      = issued_q & ~(pop & (cnt_q == 2'd0));

  assign o_str_valid = str_valid;
  assign o_str_data  = str_valid ? head : '0;
  assign o_str_busy  = busy_q;
  assign o_str_done  = done_q;

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= live;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      issued_q   <= 1'b0;
      iss_bank_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      issued_q <= issue;
      if (issue) iss_bank_q <= str_bank;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop_st) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_st};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      str_word_q <= '0;
      iss_rem_q  <= '0;
      beat_rem_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_str_start) begin
            str_word_q <= 30'(i_str_addr[31:2] % 30'(TOTAL));
            iss_rem_q  <= i_str_len;
            beat_rem_q <= i_str_len;
            if (i_str_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            str_word_q <= str_next;
            iss_rem_q  <= iss_rem_q - LW'(1);
          end
          if (pop) begin
            beat_rem_q <= beat_rem_q - LW'(1);
            if (beat_rem_q == LW'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_buffer_banked.sv
// Scoreboard bench for pim_buffer_banked: directed CPU and stream traffic,
// a negedge monitor pops expected words as the DUT presents them.
module tb_pim_buffer_banked;

  localparam int TOTAL = 2 * 3584;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_buf_addr = '0;
  logic [31:0] i_buf_wr_data = '0;
  logic [3:0]  i_buf_size = '0;
  logic        i_buf_write = 1'b0;
  logic        i_buf_read = 1'b0;
  logic [31:0] o_buf_rd_data;
  logic        o_buf_rd_valid;
  logic        i_str_start = 1'b0;
  logic [31:0] i_str_addr = '0;
  logic [12:0] i_str_len = '0;
  logic        o_str_busy;
  logic [31:0] o_str_data;
  logic        o_str_valid;
  logic        i_str_ready = 1'b1;
  logic        o_str_done;

  pim_buffer_banked dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_buf_addr     (i_buf_addr),
    .i_buf_wr_data  (i_buf_wr_data),
    .i_buf_size     (i_buf_size),
    .i_buf_write    (i_buf_write),
    .i_buf_read     (i_buf_read),
    .o_buf_rd_data  (o_buf_rd_data),
    .o_buf_rd_valid (o_buf_rd_valid),
    .i_str_start    (i_str_start),
    .i_str_addr     (i_str_addr),
    .i_str_len      (i_str_len),
    .o_str_busy     (o_str_busy),
    .o_str_data     (o_str_data),
    .o_str_valid    (o_str_valid),
    .i_str_ready    (i_str_ready),
    .o_str_done     (o_str_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int pops   = 0;
  int first_pop = -1;
  int last_pop  = -1;
  logic [31:0] exp_cpu [$];
  logic [31:0] exp_str [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic miss(input string nm);
    n_tot++;
    $display("FAIL %s: got event with nothing expected", nm);
  endtask

  // Monitor: compares whatever the DUT presents against the queues
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_buf_rd_valid) begin
        if (exp_cpu.size() == 0) miss("cpu_rd");
        else chk("cpu_rd", o_buf_rd_data, exp_cpu.pop_front());
      end
      if (o_str_valid && !i_str_ready && exp_str.size() != 0)
        chk("str_hold", o_str_data, exp_str[0]);
      if (o_str_valid && i_str_ready) begin
        if (exp_str.size() == 0) miss("str_beat");
        else chk("str_beat", o_str_data, exp_str.pop_front());
        pops++;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d,
                           input logic [3:0] s);
    i_buf_addr = a; i_buf_wr_data = d; i_buf_size = s; i_buf_write = 1'b1;
    tick();
    i_buf_write = 1'b0;
  endtask

  task automatic cpu_read(input int a, input logic [31:0] e);
    exp_cpu.push_back(e);
    i_buf_addr = a; i_buf_read = 1'b1;
    tick();
    i_buf_read = 1'b0;
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: CPU hits bank 0
  task automatic burst(input int w, input int len, input int mode);
    int s, k;
    bit got;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < len; i++) exp_str.push_back(32'((w + i) % TOTAL));
    first_pop = -1;
    i_str_addr = w * 4; i_str_len = 13'(len); i_str_start = 1'b1;
    s = cyc;
    tick();
    i_str_start = 1'b0;
    chk("busy_start", {31'd0, o_str_busy}, {31'd0, len != 0});
    k = 0; got = 0;
    while (!got && k < 300) begin
      if (o_str_done) got = 1;
      else begin
        if (mode == 1) i_str_ready = pat[k % 4];
        if (mode == 2) begin
          i_buf_read = (k % 2 == 0);
          if (i_buf_read) begin
            i_buf_addr = ((k / 2) % 8) * 8;
            exp_cpu.push_back(32'(((k / 2) % 8) * 2));
          end
        end
        tick();
        k++;
      end
    end
    i_buf_read = 1'b0;
    i_str_ready = 1'b1;
    if (!got) miss("done_timeout");
    else if (len == 0) chk("done_len0", 32'(cyc - s), 32'd1);
    else chk("done_lat", 32'(cyc), 32'(last_pop + 1));
    if (mode == 0 && len > 0) begin
      chk("first_valid", 32'(first_pop - s), 32'd2);
      chk("throughput", 32'(last_pop - first_pop), 32'(len - 1));
    end
    tick();
    chk("done_pulse", {31'd0, o_str_done}, 32'd0);
    chk("busy_end", {31'd0, o_str_busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_rd_valid", {31'd0, o_buf_rd_valid}, 32'd0);
    chk("rst_rd_data", o_buf_rd_data, 32'd0);
    chk("rst_str_valid", {31'd0, o_str_valid}, 32'd0);
    chk("rst_str_data", o_str_data, 32'd0);
    chk("rst_busy", {31'd0, o_str_busy}, 32'd0);
    chk("rst_done", {31'd0, o_str_done}, 32'd0);
    i_reset = 1'b0;
    tick();

    // Byte strobes and read latency
    cpu_write(32'h8, 32'h0, 4'hF);
    cpu_write(32'h8, 32'hDEADBEEF, 4'b0101);
    cpu_read(32'h8, 32'h00AD00EF);
    chk("rd_latency", {31'd0, o_buf_rd_valid}, 32'd1);
    tick();
    chk("rd_hold_valid", {31'd0, o_buf_rd_valid}, 32'd0);
    chk("rd_hold_data", o_buf_rd_data, 32'h00AD00EF);

    // Write wins over a simultaneous read
    i_buf_addr = 32'h8; i_buf_wr_data = 32'h11223344; i_buf_size = 4'hF;
    i_buf_write = 1'b1; i_buf_read = 1'b1;
    tick();
    i_buf_write = 1'b0; i_buf_read = 1'b0;
    chk("wr_rd_novalid", {31'd0, o_buf_rd_valid}, 32'd0);
    cpu_read(32'h8, 32'h11223344);

    for (int i = 0; i < 16; i++) cpu_write(i * 4, 32'(i), 4'hF);
    cpu_write((TOTAL - 1) * 4, 32'(TOTAL - 1), 4'hF);
    cpu_read(TOTAL * 4 + 4, 32'd1);
    tick();

    burst(0, 16, 0);
    burst(0, 16, 1);
    burst(0, 16, 2);
    burst(TOTAL - 1, 3, 0);
    burst(0, 0, 0);

    // Reset in the middle of a burst
    first_pop = -1;
    pops = 0;
    for (int i = 0; i < 16; i++) exp_str.push_back(32'(i));
    i_str_addr = 0; i_str_len = 13'd16; i_str_start = 1'b1;
    tick();
    i_str_start = 1'b0;
    for (int k = 0; k < 50 && pops < 5; k++) tick();
    chk("beats_before_rst", 32'(pops), 32'd5);
    i_reset = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, o_str_valid}, 32'd0);
    chk("midrst_busy", {31'd0, o_str_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_str_done}, 32'd0);
    exp_str.delete();
    i_reset = 1'b0;
    tick();
    chk("postrst_done", {31'd0, o_str_done}, 32'd0);
    burst(4, 4, 0);
    cpu_read(32'hC, 32'd3);

    tick(); tick(); tick();
    chk("cpu_q_empty", 32'(exp_cpu.size()), 32'd0);
    chk("str_q_empty", 32'(exp_str.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
